// File: rtl/gost_pkg.sv
// Shared types and widths for the two-requester GOST job arbiter.
// Everything that the arbiter and its operand slots must agree on lives here.
package gost_pkg;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 256;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

endpackage

// File: rtl/gost_req_slot.sv
// Operand latch for one requester: captures a job when it is granted and
// presents it to the shared core bus only while this requester owns the core.
module gost_req_slot
    import gost_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_sel,
    input  logic              i_encDec,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEY_W-1:0]  i_key,
    output logic              o_encDec,
    output logic [DATA_W-1:0] o_data,
    output logic [KEY_W-1:0]  o_key
);

    logic              r_encDec;
    logic [DATA_W-1:0] r_data;
    logic [KEY_W-1:0]  r_key;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_encDec <= 1'b0;
            r_data   <= '0;
            r_key    <= '0;
        end else if (i_load) begin
            r_encDec <= i_encDec;
            r_data   <= i_data;
            r_key    <= i_key;
        end
    end

    // Unselected slots drive zero so the top can simply OR both slots together.
    assign o_encDec = i_sel & r_encDec;
    assign o_data   = i_sel ? r_data : '0;
    assign o_key    = i_sel ? r_key  : '0;

endmodule

// File: rtl/gost_req_arbiter.sv
// Round-robin arbiter sharing one externally instantiated GOST core between two
// requesters, with a watchdog that aborts a job the core never finishes.
module gost_req_arbiter
    import gost_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_enc_dec,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [KEY_W-1:0]  req0_key,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_enc_dec,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [KEY_W-1:0]  req1_key,

    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,

    output logic              core_start,
    output logic              core_enc_dec,
    output logic [DATA_W-1:0] core_data_i,
    output logic [KEY_W-1:0]  core_key_i,
    input  logic [DATA_W-1:0] core_data_o,
    input  logic              core_busy,
    input  logic              core_ready
);

    state_t            r_state;
    state_t            w_nextState;

    logic              r_prio;
    logic              r_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;

    logic [1:0]        r_rspValid;
    logic              r_rspError;
    logic [DATA_W-1:0] r_rspData;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;

    logic              w_enc0;
    logic              w_enc1;
    logic [DATA_W-1:0] w_data0;
    logic [DATA_W-1:0] w_data1;
    logic [KEY_W-1:0]  w_key0;
    logic [KEY_W-1:0]  w_key1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        w_cntNext   = r_cnt + CNT_W'(1);
        case (r_state)
            S_IDLE: begin
                // r_prio names the requester that wins a tie.
                if (!core_busy && (req0_valid || req1_valid)) begin
                    w_accept = 1'b1;
                    if (req0_valid && req1_valid) begin
                        w_grant0 = ~r_prio;
                        w_grant1 = r_prio;
                    end else begin
                        w_grant0 = req0_valid;
                        w_grant1 = req1_valid;
                    end
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (core_ready) begin
                    w_done      = 1'b1;
                    w_nextState = S_DELIVER;
                end else if (w_cntNext == CNT_W'(TIMEOUT_CYCLES)) begin
                    w_done      = 1'b1;
                    w_timeout   = 1'b1;
                    w_nextState = S_DELIVER;
                end
            end
            S_DELIVER: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, watchdog counter and the registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio     <= 1'b0;
            r_grant    <= 1'b0;
            r_cnt      <= '0;
            r_rspValid <= 2'b00;
            r_rspError <= 1'b0;
            r_rspData  <= '0;
        end else begin
            r_rspValid <= 2'b00;
            r_rspError <= 1'b0;
            if (w_accept) begin
                r_grant <= w_grant1;
                r_prio  <= w_grant0;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= w_cntNext;
            end
            if (w_done) begin
                r_rspValid <= r_grant ? 2'b10 : 2'b01;
                r_rspError <= w_timeout;
                r_rspData  <= w_timeout ? '0 : core_data_o;
            end
        end
    end

    gost_req_slot u_slot0 (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_grant0),
        .i_sel    (~r_grant),
        .i_encDec (req0_enc_dec),
        .i_data   (req0_data),
        .i_key    (req0_key),
        .o_encDec (w_enc0),
        .o_data   (w_data0),
        .o_key    (w_key0)
    );

    gost_req_slot u_slot1 (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_grant1),
        .i_sel    (r_grant),
        .i_encDec (req1_enc_dec),
        .i_data   (req1_data),
        .i_key    (req1_key),
        .o_encDec (w_enc1),
        .o_data   (w_data1),
        .o_key    (w_key1)
    );

    // Outputs are forced low while reset is held, even before the first edge.
    assign req0_ready   = ~reset & w_grant0;
    assign req1_ready   = ~reset & w_grant1;
    assign core_start   = ~reset & (r_state == S_ISSUE);
    assign core_enc_dec = ~reset & (w_enc0 | w_enc1);
    assign core_data_i  = reset ? '0 : (w_data0 | w_data1);
    assign core_key_i   = reset ? '0 : (w_key0 | w_key1);
    assign rsp_valid    = reset ? 2'b00 : r_rspValid;
    assign rsp_error    = ~reset & r_rspError;
    assign rsp_data     = reset ? '0 : r_rspData;

endmodule
